// File: rtl/booth_csa_multiplier.sv
// Sequential radix-4 Booth signed multiplier: one partial product per cycle folded into
// the accumulator through a 3-input carry-save adder; DATA_WIDTH/2 cycles from start to done.

module csa #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] result
);
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;

  assign sum    = a ^ b ^ c;
  assign carry  = (a & b) | (a & c) | (b & c);
  // Carry out of the top bit is dropped; the product is exact modulo 2^WIDTH.
  assign result = sum + (carry << 1);
endmodule

module booth_csa_multiplier #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] multiplicand,
  input  logic [DATA_WIDTH-1:0] multiplier,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product_hi,
  output logic [DATA_WIDTH-1:0] product_lo
);
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH / 2) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [DATA_WIDTH-1:0] m_reg, q_reg;
  logic [PW-1:0]       acc;
  logic [CNT_W-1:0]    cnt;
  logic                last;
  logic                accept;

  logic [DATA_WIDTH:0] q_ext;
  logic [CNT_W:0]      shamt;
  logic [2:0]          triplet;
  logic                neg, zero, dbl;
  logic [PW-1:0]       m_ext, mag, y;
  logic [PW-1:0]       csa_b, csa_c, csa_sum;

  assign last   = (cnt == CNT_W'(DATA_WIDTH / 2 - 1));
  assign accept = start && (state != RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Appending a zero below Q supplies the implicit Q[-1] for the first triplet.
  assign q_ext   = {q_reg, 1'b0};
  assign shamt   = {cnt, 1'b0};
  assign triplet = 3'(q_ext >> shamt);

  always_comb begin
    neg  = 1'b0;
    zero = 1'b0;
    dbl  = 1'b0;
    case (triplet)
      3'b000, 3'b111: zero = 1'b1;
      3'b001, 3'b010: ;
      3'b011:         dbl = 1'b1;
      3'b100:         begin neg = 1'b1; dbl = 1'b1; end
      default:        neg = 1'b1;
    endcase
  end

  assign m_ext = {{DATA_WIDTH{m_reg[DATA_WIDTH-1]}}, m_reg};
  assign mag   = dbl ? (m_ext << 1) : m_ext;
  assign y     = mag << shamt;
  // Negative digits are added as ~Y with a +1 injected on the third csa input.
  assign csa_b = zero ? '0 : (neg ? ~y : y);
  assign csa_c = {{(PW-1){1'b0}}, neg};

  csa #(.WIDTH(PW)) u_csa (
    .a      (acc),
    .b      (csa_b),
    .c      (csa_c),
    .result (csa_sum)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      m_reg      <= '0;
      q_reg      <= '0;
      acc        <= '0;
      cnt        <= '0;
      product_hi <= '0;
      product_lo <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        m_reg <= multiplicand;
        q_reg <= multiplier;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        acc <= csa_sum;
        if (last) begin
          {product_hi, product_lo} <= csa_sum;
          cnt                      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_booth_csa_multiplier.sv
// Scoreboard bench: expected products queued at start, popped and compared on done.
module tb_booth_csa_multiplier;
  localparam int W = 32;

  logic         clk;
  logic         clr;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;

  int vectors = 0;
  int errors  = 0;
  logic [2*W-1:0] exp_q[$];

  booth_csa_multiplier #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product_hi   (product_hi),
    .product_lo   (product_lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    longint a, b;
    a = longint'($signed(m));
    b = longint'($signed(q));
    return 64'(a * b);
  endfunction

  // Drives start for one edge, then samples at negedges until done (bounded).
  task automatic wait_done(output int busy_n, output bit seen);
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
    end
  endtask

  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q, input logic [2*W-1:0] e);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic check_result(input string name);
    logic [2*W-1:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: done with empty scoreboard, got %h", name, {product_hi, product_lo});
    end else begin
      e = exp_q.pop_front();
      if ({product_hi, product_lo} !== e) begin
        errors++;
        $display("FAIL %s: product got %h expected %h", name, {product_hi, product_lo}, e);
      end
    end
  endtask

  task automatic test_reset;
    clr = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    vectors++;
    if ({busy, done, product_hi, product_lo} !== {2'b00, 64'h0}) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b prod=%h expected 0/0/0", busy, done, {product_hi, product_lo});
    end
  endtask

  task automatic test_directed;
    logic [W-1:0]   tm [4] = '{32'h3, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0]   tq [4] = '{32'h5, 32'h6,         32'h8000_0000, 32'hFFFF_FFFF};
    logic [2*W-1:0] te [4] = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FFD6,
                               64'h4000_0000_0000_0000, 64'h0000_0000_0000_0001};
    int busy_n;
    bit seen;
    for (int k = 0; k < 4; k++) begin
      issue(tm[k], tq[k], te[k]);
      wait_done(busy_n, seen);
      vectors++;
      if (!seen || busy_n != W / 2 || busy) begin
        errors++;
        $display("FAIL directed%0d timing: seen=%b busy_cycles=%0d busy_at_done=%b expected 1/%0d/0",
                 k, seen, busy_n, busy, W / 2);
      end
      if (seen) check_result($sformatf("directed%0d", k));
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL directed%0d pulse: done=%b one cycle after done, expected 0", k, done);
      end
    end
  endtask

  task automatic test_ignore_start;
    int busy_n = 0;
    bit seen = 1'b0;
    int extra = 0;
    issue(32'd3, 32'd5, 64'hF);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin seen = 1'b1; break; end
      if (busy) begin
        busy_n++;
        if (busy_n == 4) begin
          multiplicand = 32'd2; multiplier = 32'd2; start = 1'b1;
        end
      end
    end
    vectors++;
    if (!seen || busy_n != W / 2) begin
      errors++;
      $display("FAIL ignore_start timing: seen=%b busy_cycles=%0d expected 1/%0d", seen, busy_n, W / 2);
    end
    if (seen) check_result("ignore_start");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    vectors++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_start extra: %0d busy/done cycles after result, expected 0", extra);
    end
  endtask

  task automatic test_clr_abort;
    int busy_n = 0;
    int extra = 0;
    multiplicand = 32'd9; multiplier = 32'd9; start = 1'b1;
    for (int i = 0; i < 40 && busy_n < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_n++;
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    vectors++;
    if ({busy, done, product_hi, product_lo} !== {2'b00, 64'h0}) begin
      errors++;
      $display("FAIL clr_abort: busy=%b done=%b prod=%h expected 0/0/0", busy, done, {product_hi, product_lo});
    end
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    vectors++;
    if (extra != 0) begin
      errors++;
      $display("FAIL clr_abort after: %0d busy/done cycles after clr, expected 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int busy_n;
    bit seen;
    issue(32'd100, 32'd200, 64'h4E20);
    wait_done(busy_n, seen);
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b first: no done within bound, got 0 expected 1");
    end else begin
      check_result("b2b_first");
    end
    issue(32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(busy_n, seen);
    vectors++;
    if (!seen || busy_n != W / 2) begin
      errors++;
      $display("FAIL b2b second timing: seen=%b busy_cycles=%0d expected 1/%0d", seen, busy_n, W / 2);
    end
    if (seen) check_result("b2b_second");
  endtask

  task automatic test_random;
    int busy_n;
    bit seen;
    logic [W-1:0] m, q;
    for (int k = 0; k < 1000; k++) begin
      m = $urandom();
      q = $urandom();
      case ($urandom_range(0, 7))
        0: m = 32'h8000_0000;
        1: q = 32'h7FFF_FFFF;
        2: q = 32'h0;
        default: ;
      endcase
      issue(m, q, ref_mul(m, q));
      wait_done(busy_n, seen);
      if (!seen) begin
        vectors++;
        errors++;
        $display("FAIL random%0d: no done within bound, got 0 expected 1", k);
        void'(exp_q.pop_front());
      end else begin
        check_result($sformatf("random%0d m=%h q=%h", k, m, q));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_clr_abort();
    test_back_to_back();
    test_random();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
